// File: rtl/pipe_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit_if
// Description : Pipeline-state inputs and stall/bubble outputs of the hazard
//               unit. The hazard unit takes the slave view; the pipeline
//               (or a testbench) takes the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    // Pipeline state observed by the hazard unit
    logic [3:0]       D_icode;
    logic [REG_W-1:0] d_rA;
    logic [REG_W-1:0] d_rB;
    logic [3:0]       E_icode;
    logic [REG_W-1:0] E_dstM;
    logic             e_cnd;
    logic [3:0]       M_icode;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;

    // Per-stage control and status
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             halted;
    logic [2:0]       exc_code;
    logic [CNT_W-1:0] lu_events;
    logic [CNT_W-1:0] mp_events;

    modport slave (
        input  D_icode, d_rA, d_rB, E_icode, E_dstM, e_cnd, M_icode, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output halted, exc_code, lu_events, mp_events
    );

    modport master (
        output D_icode, d_rA, d_rB, E_icode, E_dstM, e_cnd, M_icode, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  halted, exc_code, lu_events, mp_events
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Y86-style pipeline control. Produces per-stage stall/bubble
//               from D/E/M/W state: multi-cycle load-use interlock, ret and
//               misprediction handling, exception halt, saturating event
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int REG_W    = 4,
    parameter int RNONE    = 15,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_hazard_if.slave hz
);

    localparam int LU_W = $clog2(LOAD_LAT) + 1;

    localparam logic [REG_W-1:0] c_rnone     = REG_W'(RNONE);
    localparam logic [LU_W-1:0]  c_lu_reload = LU_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [3:0]       c_i_mrmovq  = 4'd5;
    localparam logic [3:0]       c_i_popq    = 4'd11;
    localparam logic [3:0]       c_i_ret     = 4'd9;
    localparam logic [3:0]       c_i_jxx     = 4'd7;
    localparam logic [2:0]       c_stat_aok  = 3'd1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [LU_W-1:0]  lu_cnt_q,    lu_cnt_d;
    logic             halted_q,    halted_d;
    logic [2:0]       exc_code_q,  exc_code_d;
    logic [CNT_W-1:0] lu_events_q, lu_events_d;
    logic [CNT_W-1:0] mp_events_q, mp_events_d;

    logic w_load_use;
    logic w_ret_in;
    logic w_mispred;
    logic w_exc_m;
    logic w_exc_w;
    logic w_lu_hold;
    logic w_lu_first;

    logic w_f_stall;
    logic w_d_stall;
    logic w_d_bubble;
    logic w_e_bubble;
    logic w_m_bubble;
    logic w_w_stall;

    // A load whose destination is RNONE never creates a dependency.
    assign w_load_use = ((hz.E_icode == c_i_mrmovq) || (hz.E_icode == c_i_popq)) &&
                        (hz.E_dstM != c_rnone) &&
                        ((hz.E_dstM == hz.d_rA) || (hz.E_dstM == hz.d_rB));
    assign w_ret_in   = (hz.D_icode == c_i_ret) || (hz.E_icode == c_i_ret) ||
                        (hz.M_icode == c_i_ret);
    assign w_mispred  = (hz.E_icode == c_i_jxx) && !hz.e_cnd;
    assign w_exc_m    = (hz.m_stat != c_stat_aok);
    assign w_exc_w    = (hz.W_stat != c_stat_aok);
    // lu_cnt holds the extra stall cycles still owed after the first one.
    assign w_lu_hold  = w_load_use || (lu_cnt_q != '0);
    // A fresh hazard is one seen while no interlock is already running.
    assign w_lu_first = w_load_use && (lu_cnt_q == '0);

    // Next-state: halt FSM, load-use down-counter and saturating counters.
    always_comb begin
        state_d     = state_q;
        lu_cnt_d    = lu_cnt_q;
        halted_d    = halted_q;
        exc_code_d  = exc_code_q;
        lu_events_d = lu_events_q;
        mp_events_d = mp_events_q;
        case (state_q)
            ST_RUN: begin
                if (w_lu_first && (LOAD_LAT > 1)) begin
                    lu_cnt_d = c_lu_reload;
                end else if (lu_cnt_q != '0) begin
                    lu_cnt_d = lu_cnt_q - LU_W'(1);
                end
                if (w_lu_first && (lu_events_q != c_cnt_max)) begin
                    lu_events_d = lu_events_q + CNT_W'(1);
                end
                if (w_mispred && (mp_events_q != c_cnt_max)) begin
                    mp_events_d = mp_events_q + CNT_W'(1);
                end
                if (w_exc_w) begin
                    state_d    = ST_HALT;
                    halted_d   = 1'b1;
                    exc_code_d = hz.W_stat;
                end
            end
            ST_HALT: begin
                lu_cnt_d = '0;
            end
            default: begin
                state_d  = ST_RUN;
                lu_cnt_d = '0;
            end
        endcase
    end

    // Control outputs: forced quiet in reset, freeze-everything in HALT.
    always_comb begin
        w_f_stall  = 1'b0;
        w_d_stall  = 1'b0;
        w_d_bubble = 1'b0;
        w_e_bubble = 1'b0;
        w_m_bubble = 1'b0;
        w_w_stall  = 1'b0;
        if (!rst_n) begin
            w_f_stall = 1'b0;
        end else if (state_q == ST_HALT) begin
            w_f_stall  = 1'b1;
            w_d_bubble = 1'b1;
            w_e_bubble = 1'b1;
            w_m_bubble = 1'b1;
            w_w_stall  = 1'b1;
        end else begin
            w_f_stall  = w_lu_hold || w_ret_in;
            // A mispredict squashes D, so it overrides the load-use stall.
            w_d_stall  = w_lu_hold && !w_mispred;
            w_d_bubble = w_mispred || (w_ret_in && !w_lu_hold);
            w_e_bubble = w_mispred || w_lu_hold;
            w_m_bubble = w_exc_m || w_exc_w;
            w_w_stall  = w_exc_w;
        end
    end

    // State registers; reset abandons any interlock in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            lu_cnt_q    <= '0;
            halted_q    <= 1'b0;
            exc_code_q  <= 3'd0;
            lu_events_q <= '0;
            mp_events_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            halted_q    <= halted_d;
            exc_code_q  <= exc_code_d;
            lu_events_q <= lu_events_d;
            mp_events_q <= mp_events_d;
        end
    end

    assign hz.F_stall   = w_f_stall;
    assign hz.D_stall   = w_d_stall;
    assign hz.D_bubble  = w_d_bubble;
    assign hz.E_bubble  = w_e_bubble;
    assign hz.M_bubble  = w_m_bubble;
    assign hz.W_stall   = w_w_stall;
    assign hz.halted    = halted_q;
    assign hz.exc_code  = exc_code_q;
    assign hz.lu_events = lu_events_q;
    assign hz.mp_events = mp_events_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_unit
// Description : Three hazard units (LOAD_LAT=1; LOAD_LAT=3; LOAD_LAT=3 with
//               2-bit counters) driven in lockstep and compared against a
//               cycle-count reference model, a vector table and directed
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    typedef struct packed {
        logic [3:0] d_icode;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] e_icode;
        logic [3:0] e_dstm;
        logic       e_cnd;
        logic [3:0] m_icode;
        logic [2:0] m_stat;
        logic [2:0] w_stat;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [5:0] exp;   // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_v = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_if #(.REG_W(4), .CNT_W(16)) if0 ();
    pipe_hazard_if #(.REG_W(4), .CNT_W(16)) if1 ();
    pipe_hazard_if #(.REG_W(4), .CNT_W(2))  if2 ();

    pipe_hazard_unit #(.REG_W(4), .RNONE(15), .LOAD_LAT(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .hz(if0));
    pipe_hazard_unit #(.REG_W(4), .RNONE(15), .LOAD_LAT(3), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .hz(if1));
    pipe_hazard_unit #(.REG_W(4), .RNONE(15), .LOAD_LAT(3), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .hz(if2));

    in_t    cur;
    int     n_pass = 0;
    int     n_tot  = 0;

    // Reference model state: remaining extra stall cycles, halt flag, counts
    int     lat[3]  = '{1, 3, 3};
    longint cmax[3] = '{65535, 65535, 3};
    int     m_rem[3];
    bit     m_halt[3];
    int     m_exc[3];
    longint m_lu[3];
    longint m_mp[3];

    logic [5:0] act_ctrl[3];
    logic       act_halt[3];
    logic [2:0] act_exc[3];
    longint     act_lu[3];
    longint     act_mp[3];

    vec_t tbl[12];

    function automatic in_t nop_in();
        in_t v;
        v.d_icode = 4'd0; v.ra = 4'd15; v.rb = 4'd15;
        v.e_icode = 4'd0; v.e_dstm = 4'd15; v.e_cnd = 1'b1;
        v.m_icode = 4'd0; v.m_stat = 3'd1; v.w_stat = 3'd1;
        return v;
    endfunction

    function automatic vec_t mk(int d, int ra, int rb, int e, int dst, int cnd,
                                int m, int ms, int ws, logic [5:0] exp);
        vec_t v;
        v.in.d_icode = 4'(d);  v.in.ra = 4'(ra);  v.in.rb = 4'(rb);
        v.in.e_icode = 4'(e);  v.in.e_dstm = 4'(dst); v.in.e_cnd = 1'(cnd);
        v.in.m_icode = 4'(m);  v.in.m_stat = 3'(ms); v.in.w_stat = 3'(ws);
        v.exp = exp;
        return v;
    endfunction

    function automatic bit f_load_use();
        return ((cur.e_icode == 4'd5) || (cur.e_icode == 4'd11)) && (cur.e_dstm != 4'd15) &&
               ((cur.e_dstm == cur.ra) || (cur.e_dstm == cur.rb));
    endfunction

    function automatic logic [5:0] model_ctrl(int i);
        bit ret, mp, hold, ew, em;
        if (!rst_n)    return 6'b000000;
        if (m_halt[i]) return 6'b101111;
        ret  = (cur.d_icode == 4'd9) || (cur.e_icode == 4'd9) || (cur.m_icode == 4'd9);
        mp   = (cur.e_icode == 4'd7) && !cur.e_cnd;
        hold = f_load_use() || (m_rem[i] > 0);
        em   = (cur.m_stat != 3'd1);
        ew   = (cur.w_stat != 3'd1);
        return {hold || ret, hold && !mp, mp || (ret && !hold), mp || hold, em || ew, ew};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rem[i] = 0; m_halt[i] = 1'b0; m_exc[i] = 0; m_lu[i] = 0; m_mp[i] = 0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        for (int i = 0; i < 3; i++) begin
            if (m_halt[i]) begin
                m_rem[i] = 0;
            end else begin
                if (f_load_use() && m_rem[i] == 0) begin
                    if (m_lu[i] < cmax[i]) m_lu[i]++;
                    m_rem[i] = lat[i] - 1;
                end else if (m_rem[i] > 0) begin
                    m_rem[i]--;
                end
                if (cur.e_icode == 4'd7 && !cur.e_cnd && m_mp[i] < cmax[i]) m_mp[i]++;
                if (cur.w_stat != 3'd1) begin
                    m_halt[i] = 1'b1;
                    m_exc[i]  = int'(cur.w_stat);
                end
            end
        end
    endtask

    task automatic chk(string nm, longint act, longint exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive_ifs();
        rst_n = rst_v;
        if0.D_icode = cur.d_icode; if0.d_rA = cur.ra; if0.d_rB = cur.rb;
        if0.E_icode = cur.e_icode; if0.E_dstM = cur.e_dstm; if0.e_cnd = cur.e_cnd;
        if0.M_icode = cur.m_icode; if0.m_stat = cur.m_stat; if0.W_stat = cur.w_stat;
        if1.D_icode = cur.d_icode; if1.d_rA = cur.ra; if1.d_rB = cur.rb;
        if1.E_icode = cur.e_icode; if1.E_dstM = cur.e_dstm; if1.e_cnd = cur.e_cnd;
        if1.M_icode = cur.m_icode; if1.m_stat = cur.m_stat; if1.W_stat = cur.w_stat;
        if2.D_icode = cur.d_icode; if2.d_rA = cur.ra; if2.d_rB = cur.rb;
        if2.E_icode = cur.e_icode; if2.E_dstM = cur.e_dstm; if2.e_cnd = cur.e_cnd;
        if2.M_icode = cur.m_icode; if2.m_stat = cur.m_stat; if2.W_stat = cur.w_stat;
    endtask

    task automatic sample();
        act_ctrl[0] = {if0.F_stall, if0.D_stall, if0.D_bubble, if0.E_bubble, if0.M_bubble, if0.W_stall};
        act_ctrl[1] = {if1.F_stall, if1.D_stall, if1.D_bubble, if1.E_bubble, if1.M_bubble, if1.W_stall};
        act_ctrl[2] = {if2.F_stall, if2.D_stall, if2.D_bubble, if2.E_bubble, if2.M_bubble, if2.W_stall};
        act_halt[0] = if0.halted; act_halt[1] = if1.halted; act_halt[2] = if2.halted;
        act_exc[0]  = if0.exc_code; act_exc[1] = if1.exc_code; act_exc[2] = if2.exc_code;
        act_lu[0] = longint'(if0.lu_events); act_lu[1] = longint'(if1.lu_events);
        act_lu[2] = longint'(if2.lu_events);
        act_mp[0] = longint'(if0.mp_events); act_mp[1] = longint'(if1.mp_events);
        act_mp[2] = longint'(if2.mp_events);
    endtask

    // Apply inputs mid-cycle, compare everything against the model before the edge
    task automatic step();
        @(negedge clk);
        drive_ifs();
        #1;
        if (!rst_n) model_reset();
        sample();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ctrl%0d", i),   longint'(act_ctrl[i]), longint'(model_ctrl(i)));
            chk($sformatf("halted%0d", i), longint'(act_halt[i]), longint'(m_halt[i]));
            chk($sformatf("exc%0d", i),    longint'(act_exc[i]),  longint'(m_exc[i]));
            chk($sformatf("lu_ev%0d", i),  act_lu[i], m_lu[i]);
            chk($sformatf("mp_ev%0d", i),  act_mp[i], m_mp[i]);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
    endtask

    task automatic cyc();
        step();
        tick();
    endtask

    task automatic do_reset();
        rst_v = 1'b0;
        cur   = nop_in();
        cyc();
        cyc();
        rst_v = 1'b1;
    endtask

    function automatic logic [3:0] pick_reg();
        case ($urandom_range(0, 4))
            0: return 4'd1;
            1: return 4'd2;
            2: return 4'd3;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [3:0] pick_icode();
        case ($urandom_range(0, 7))
            0: return 4'd5;
            1: return 4'd11;
            2: return 4'd7;
            3: return 4'd9;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [2:0] pick_stat(int odds);
        if ($urandom_range(0, odds) == 0) return 3'($urandom_range(2, 4));
        return 3'd1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(0, 15, 15,  0, 15, 1, 0, 1, 1, 6'b000000); // idle
        tbl[1]  = mk(0,  3, 15,  5,  3, 1, 0, 1, 1, 6'b110100); // mrmovq -> rA
        tbl[2]  = mk(0,  0, 15, 11, 15, 1, 0, 1, 1, 6'b000000); // popq to RNONE
        tbl[3]  = mk(0, 15,  2,  5,  2, 1, 0, 1, 1, 6'b110100); // mrmovq -> rB
        tbl[4]  = mk(0,  5,  6, 11,  4, 1, 0, 1, 1, 6'b000000); // no match
        tbl[5]  = mk(9, 15, 15,  7, 15, 0, 0, 1, 1, 6'b101100); // mispred + ret in D
        tbl[6]  = mk(0, 15, 15,  7, 15, 1, 0, 1, 1, 6'b000000); // jump taken
        tbl[7]  = mk(9, 15, 15,  0, 15, 1, 0, 1, 1, 6'b101000); // ret in D
        tbl[8]  = mk(0, 15, 15,  0, 15, 1, 9, 1, 1, 6'b101000); // ret in M
        tbl[9]  = mk(9,  3, 15,  5,  3, 1, 0, 1, 1, 6'b110100); // load-use beats ret
        tbl[10] = mk(0, 15, 15,  0, 15, 1, 0, 3, 1, 6'b000010); // M-stage exception
        tbl[11] = mk(0, 15, 15,  9, 15, 1, 0, 4, 1, 6'b101010); // ret in E + exc_m

        model_reset();
        cur = nop_in();
        do_reset();

        // Vector table against the single-cycle-interlock instance
        for (int k = 0; k < 12; k++) begin
            cur = tbl[k].in;
            step();
            chk($sformatf("tbl%0d", k), longint'(act_ctrl[0]), longint'(tbl[k].exp));
            tick();
        end

        // Single vs. three-cycle load-use interlock
        do_reset();
        cur = nop_in(); cur.e_icode = 4'd5; cur.e_dstm = 4'd3; cur.ra = 4'd3;
        step();
        chk("lu_lat1_c0", longint'(act_ctrl[0]), longint'(6'b110100));
        chk("lu_lat3_c0", longint'(act_ctrl[1]), longint'(6'b110100));
        tick();
        cur = nop_in();
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("lu_lat1_c%0d", c + 1), longint'(act_ctrl[0]), 0);
            chk($sformatf("lu_lat3_c%0d", c + 1), longint'(act_ctrl[1]),
                (c < 2) ? longint'(6'b110100) : 0);
            tick();
        end
        chk("lu_events0", act_lu[0], 1);
        chk("lu_events1", act_lu[1], 1);
        // RNONE destination never interlocks
        cur = nop_in(); cur.e_icode = 4'd11; cur.e_dstm = 4'd15; cur.rb = 4'd15; cur.ra = 4'd0;
        step();
        chk("rnone_ctrl", longint'(act_ctrl[1]), 0);
        tick();
        cur = nop_in();
        step();
        chk("rnone_lu_ev", act_lu[1], 1);
        tick();

        // Mispredict with ret in D
        do_reset();
        cur = nop_in(); cur.d_icode = 4'd9; cur.e_icode = 4'd7; cur.e_cnd = 1'b0;
        step();
        chk("mispred_ctrl", longint'(act_ctrl[0]), longint'(6'b101100));
        tick();
        cur = nop_in();
        step();
        chk("mispred_cnt", act_mp[0], 1);
        tick();

        // Exception sequence into HALT and back out through reset
        do_reset();
        cur = nop_in(); cur.m_stat = 3'd3;
        step();
        chk("exc_m_ctrl", longint'(act_ctrl[0]), longint'(6'b000010));
        tick();
        cur = nop_in(); cur.w_stat = 3'd3;
        step();
        chk("exc_w_ctrl", longint'(act_ctrl[0]), longint'(6'b000011));
        chk("exc_w_halted", longint'(act_halt[0]), 0);
        tick();
        cur = nop_in(); cur.e_icode = 4'd7; cur.e_cnd = 1'b0;
        step();
        chk("halt_halted", longint'(act_halt[1]), 1);
        chk("halt_exc", longint'(act_exc[1]), 3);
        chk("halt_ctrl", longint'(act_ctrl[1]), longint'(6'b101111));
        tick();
        cur = nop_in();
        step();
        chk("halt_no_count", act_mp[0], 0);
        tick();
        rst_v = 1'b0;
        step();
        chk("unhalt_halted", longint'(act_halt[0]), 0);
        chk("unhalt_ctrl", longint'(act_ctrl[0]), 0);
        tick();
        rst_v = 1'b1;
        cyc();

        // Counter saturation at 2^CNT_W-1
        do_reset();
        cur = nop_in(); cur.e_icode = 4'd7; cur.e_cnd = 1'b0;
        repeat (5) cyc();
        cur = nop_in();
        step();
        chk("sat_mp2", act_mp[2], 3);
        chk("sat_mp0", act_mp[0], 5);
        tick();

        // Reset in the middle of a three-cycle interlock
        cur = nop_in(); cur.e_icode = 4'd11; cur.e_dstm = 4'd1; cur.rb = 4'd1;
        cyc();
        cur = nop_in();
        step();
        chk("midrst_stalling", longint'(act_ctrl[1]), longint'(6'b110100));
        tick();
        rst_v = 1'b0;
        step();
        chk("midrst_in_reset", longint'(act_ctrl[1]), 0);
        tick();
        rst_v = 1'b1;
        step();
        chk("midrst_after", longint'(act_ctrl[1]), 0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cur.d_icode = pick_icode();
            cur.ra      = pick_reg();
            cur.rb      = pick_reg();
            cur.e_icode = pick_icode();
            cur.e_dstm  = pick_reg();
            cur.e_cnd   = 1'($urandom_range(0, 1));
            cur.m_icode = pick_icode();
            cur.m_stat  = pick_stat(8);
            cur.w_stat  = pick_stat(30);
            rst_v       = ($urandom_range(0, 59) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
